run_ctrl: RTL and testbench

//   Parametrised reset/run sequencer for the multi-cycle processor; sits between MCLK/MRST and TopLevel.

---
 rtl/run_ctrl.sv | 158 +++++++++++++++
 tb/tb_run_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Reset/run sequencer for the multi-cycle core: reset hold, run with cycle budget, halt and single-step.
// Optional breakpoint/pause support is compiled in with `define BREAKPOINT_EN.
module run_ctrl #(
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 200,
   parameter int CNT_W      = 16,
   parameter int PC_W       = 32
) (
   input  logic             MCLK,
   input  logic             MRST,
   input  logic             start,
   input  logic             halt_req,
   input  logic             step_mode,
   input  logic             step,
   output logic             core_rst,
   output logic             core_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done,
   output logic             timeout
`ifdef BREAKPOINT_EN
   ,
   input  logic [PC_W-1:0]  pc_in,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_valid,
   output logic             bp_hit
`endif
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]    HOLD_LAST   = RW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT     = '1;

   if (RST_CYCLES < 1 || PC_W < 1) begin : g_param_check
      $error("run_ctrl: RST_CYCLES and PC_W must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_RUN,
      S_DONE
`ifdef BREAKPOINT_EN
      , S_PAUSE
`endif
   } state_t;

   state_t           state_reg, state_next;
   logic [RW-1:0]    rst_cnt_reg, rst_cnt_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             done_reg, done_next;
   logic             timeout_reg, timeout_next;
`ifdef BREAKPOINT_EN
   logic             bp_hit_reg, bp_hit_next;
   logic             mask_reg, mask_next;
`endif
   logic             en;

   always_comb begin
      state_next   = state_reg;
      rst_cnt_next = rst_cnt_reg;
      cnt_next     = cnt_reg;
      done_next    = done_reg;
      timeout_next = timeout_reg;
`ifdef BREAKPOINT_EN
      bp_hit_next  = bp_hit_reg;
      mask_next    = mask_reg;
`endif
      en       = 1'b0;
      core_rst = 1'b0;

      case (state_reg)
         S_IDLE, S_DONE: begin
            core_rst = (state_reg == S_IDLE);
            if (start) begin
               state_next   = S_HOLD;
               rst_cnt_next = '0;
               cnt_next     = '0;
               done_next    = 1'b0;
               timeout_next = 1'b0;
`ifdef BREAKPOINT_EN
               bp_hit_next  = 1'b0;
               mask_next    = 1'b0;
`endif
            end
         end
         S_HOLD: begin
            core_rst = 1'b1;
            if (rst_cnt_reg == HOLD_LAST) state_next = S_RUN;
            else                          rst_cnt_next = rst_cnt_reg + 1'b1;
         end
         S_RUN: begin
            en = step_mode ? step : 1'b1;
            if (en && cnt_reg != CNT_SAT) cnt_next = cnt_reg + 1'b1;
            // Priority: halt, then budget, then breakpoint; the deciding cycle is always counted.
            if (halt_req) begin
               state_next = S_DONE;
               done_next  = 1'b1;
            end else if (en && MAX_CYCLES != 0 && cnt_reg == BUDGET_LAST) begin
               state_next   = S_DONE;
               done_next    = 1'b1;
               timeout_next = 1'b1;
            end
`ifdef BREAKPOINT_EN
            else if (en && bp_valid && pc_in == bp_addr && !mask_reg) begin
               state_next  = S_PAUSE;
               bp_hit_next = 1'b1;
            end
            // The mask lives until the core actually advances past the trapped PC.
            if (en) mask_next = 1'b0;
`endif
         end
`ifdef BREAKPOINT_EN
         S_PAUSE: begin
            if (start) begin
               state_next  = S_RUN;
               bp_hit_next = 1'b0;
               mask_next   = 1'b1;
            end
         end
`endif
         default: state_next = S_IDLE;
      endcase
      core_en = en;
   end

   always_ff @(posedge MCLK or posedge MRST) begin
      if (MRST) begin
         state_reg   <= S_IDLE;
         rst_cnt_reg <= '0;
         cnt_reg     <= '0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
`ifdef BREAKPOINT_EN
         bp_hit_reg  <= 1'b0;
         mask_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         rst_cnt_reg <= rst_cnt_next;
         cnt_reg     <= cnt_next;
         done_reg    <= done_next;
         timeout_reg <= timeout_next;
`ifdef BREAKPOINT_EN
         bp_hit_reg  <= bp_hit_next;
         mask_reg    <= mask_next;
`endif
      end
   end

   assign cycle_cnt = cnt_reg;
   assign done      = done_reg;
   assign timeout   = timeout_reg;
`ifdef BREAKPOINT_EN
   assign bp_hit    = bp_hit_reg;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl (default build): reset hold, budget timeout, halt, single-step,
// asynchronous mid-run reset and the halt-versus-budget tie.
module tb_run_ctrl;

   logic        MCLK = 1'b0;
   logic        MRST = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic        core_rst;
   logic        core_en;
   logic [15:0] cycle_cnt;
   logic        done;
   logic        timeout;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 MCLK = ~MCLK;

   run_ctrl dut (
      .MCLK      (MCLK),
      .MRST      (MRST),
      .start     (start),
      .halt_req  (halt_req),
      .step_mode (step_mode),
      .step      (step),
      .core_rst  (core_rst),
      .core_en   (core_en),
      .cycle_cnt (cycle_cnt),
      .done      (done),
      .timeout   (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
      $display("check %-18s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   // start pulse plus the two HOLD cycles; returns in the first RUN cycle
   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int n;
      int en_cnt;

      #2;
      check("rst_core_rst", core_rst, 1);
      check("rst_core_en", core_en, 0);
      check("rst_cnt", cycle_cnt, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      tick();
      tick();
      MRST = 1'b0;
      tick();
      check("idle_core_rst", core_rst, 1);

      // reset hold of two cycles, then free run into the budget
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hold1_core_rst", core_rst, 1);
      check("hold1_core_en", core_en, 0);
      tick();
      check("hold2_core_rst", core_rst, 1);
      tick();
      check("run_core_rst", core_rst, 0);
      check("run_core_en", core_en, 1);
      check("run_cnt0", cycle_cnt, 0);
      n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      check("budget_edges", n, 200);
      check("budget_done", done, 1);
      check("budget_timeout", timeout, 1);
      check("budget_cnt", cycle_cnt, 200);
      check("budget_core_en", core_en, 0);
      check("done_core_rst", core_rst, 0);
      tick();
      tick();
      check("done_hold_cnt", cycle_cnt, 200);
      check("done_hold_en", core_en, 0);

      // halt at cnt=37; the halt cycle is counted
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_done_clr", done, 0);
      check("restart_to_clr", timeout, 0);
      check("restart_cnt_clr", cycle_cnt, 0);
      tick();
      tick();
      n = 0;
      while (cycle_cnt != 37 && n < 100) begin
         tick();
         n++;
      end
      check("halt_reach37", cycle_cnt, 37);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("halt_done", done, 1);
      check("halt_timeout", timeout, 0);
      check("halt_cnt", cycle_cnt, 38);
      check("halt_core_en", core_en, 0);

      // single-step: step outside RUN ignored, then 5 pulses over 20 cycles
      start = 1'b1;
      tick();
      start = 1'b0;
      step_mode = 1'b1;
      step = 1'b1;
      #1;
      check("step_in_hold_en", core_en, 0);
      step = 1'b0;
      tick();
      tick();
      check("step_run_en_idle", core_en, 0);
      en_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step = (i % 4 == 0);
         #1;
         if (core_en) en_cnt++;
         tick();
      end
      step = 1'b0;
      check("step_cnt", cycle_cnt, 5);
      check("step_en_cycles", en_cnt, 5);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("step_halt_cnt", cycle_cnt, 5);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_in_done_cnt", cycle_cnt, 5);
      step_mode = 1'b0;

      // asynchronous reset in the middle of a run
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 90; i++) tick();
      check("mid_cnt90", cycle_cnt, 90);
      MRST = 1'b1;
      #1;
      check("mid_rst_core_rst", core_rst, 1);
      check("mid_rst_cnt", cycle_cnt, 0);
      check("mid_rst_core_en", core_en, 0);
      MRST = 1'b0;
      tick();
      check("mid_idle_core_rst", core_rst, 1);
      launch();
      check("mid_rerun_en", core_en, 1);
      tick();
      tick();
      tick();
      check("mid_rerun_cnt", cycle_cnt, 3);

      // halt and budget on the same edge: halt wins, the cycle still counts
      n = 0;
      while (cycle_cnt != 199 && n < 300) begin
         tick();
         n++;
      end
      check("tie_reach199", cycle_cnt, 199);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("tie_done", done, 1);
      check("tie_timeout", timeout, 0);
      check("tie_cnt", cycle_cnt, 200);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
